// File: rtl/cpu_writeback_arbiter.sv
// Writeback stage: merges never-stalling ALU results with buffered load
// returns onto one register-bank write port, preserving write order.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   alu_valid/reg/data  ALU result (highest priority)
//   alu_stall           registered one-cycle bubble request when loads starve
//   ld_valid/reg/data   load return, accepted when ld_valid & ld_ready
//   ld_ready            load buffer not full
//   write_enable/reg/data  registered register-bank write port
//   fifo_count          buffered loads, including killed ones
module cpu_writeback_arbiter #(
  parameter int NUM_REGS     = 16,
  parameter int REG_WIDTH    = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 3,
  localparam int RW = $clog2(NUM_REGS),
  localparam int PW = $clog2(FIFO_DEPTH),
  localparam int CW = PW + 1,
  localparam int SW = $clog2(STARVE_LIMIT + 1)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [RW-1:0]        alu_reg,
  input  logic [REG_WIDTH-1:0] alu_data,
  output logic                 alu_stall,
  input  logic                 ld_valid,
  output logic                 ld_ready,
  input  logic [RW-1:0]        ld_reg,
  input  logic [REG_WIDTH-1:0] ld_data,
  output logic                 write_enable,
  output logic [RW-1:0]        write_reg,
  output logic [REG_WIDTH-1:0] write_data,
  output logic [CW-1:0]        fifo_count
);

  logic [RW-1:0]        ent_reg_q  [FIFO_DEPTH];
  logic [RW-1:0]        ent_reg_d  [FIFO_DEPTH];
  logic [REG_WIDTH-1:0] ent_data_q [FIFO_DEPTH];
  logic [REG_WIDTH-1:0] ent_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] live_q, live_d;

  logic [PW-1:0]        rd_q, rd_d;
  logic [PW-1:0]        wr_q, wr_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [SW-1:0]        starve_q, starve_d, starve_nx;
  logic                 stall_q, stall_d;
  logic                 we_q, we_d;
  logic [RW-1:0]        wreg_q, wreg_d;
  logic [REG_WIDTH-1:0] wdata_q, wdata_d;

  logic empty, full, head_live;
  logic pop, byp, push, kill_new;

  assign empty     = (cnt_q == '0);
  assign full      = (cnt_q == CW'(FIFO_DEPTH));
  assign head_live = !empty && live_q[rd_q];
  assign pop       = !alu_valid && !empty;
  // Bypass only when nothing older is buffered, so ordering holds.
  assign byp       = !alu_valid && empty && ld_valid;
  assign push      = ld_valid && !full && !byp;
  assign kill_new  = alu_valid && (ld_reg == alu_reg);

  assign ld_ready     = !full;
  assign alu_stall    = stall_q;
  assign write_enable = we_q;
  assign write_reg    = wreg_q;
  assign write_data   = wdata_q;
  assign fifo_count   = cnt_q;

  always_comb begin
    ent_reg_d  = ent_reg_q;
    ent_data_d = ent_data_q;
    live_d     = live_q;
    // A younger ALU write makes older buffered loads to that reg stale.
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (alu_valid && ent_reg_q[i] == alu_reg) live_d[i] = 1'b0;
    end
    if (push) begin
      ent_reg_d[wr_q]  = ld_reg;
      ent_data_d[wr_q] = ld_data;
      live_d[wr_q]     = !kill_new;
    end
    wr_d  = push ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_comb begin
    we_d    = 1'b0;
    wreg_d  = wreg_q;
    wdata_d = wdata_q;
    unique case (1'b1)
      alu_valid: begin
        we_d    = 1'b1;
        wreg_d  = alu_reg;
        wdata_d = alu_data;
      end
      pop: begin
        if (head_live) begin
          we_d    = 1'b1;
          wreg_d  = ent_reg_q[rd_q];
          wdata_d = ent_data_q[rd_q];
        end
      end
      byp: begin
        we_d    = 1'b1;
        wreg_d  = ld_reg;
        wdata_d = ld_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    starve_nx = starve_q;
    if (alu_valid && head_live) starve_nx = starve_q + 1'b1;
    if (pop || empty) starve_nx = '0;
    stall_d  = 1'b0;
    starve_d = starve_nx;
    if (starve_nx == SW'(STARVE_LIMIT)) begin
      stall_d  = 1'b1;
      starve_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      live_q   <= '0;
      rd_q     <= '0;
      wr_q     <= '0;
      cnt_q    <= '0;
      starve_q <= '0;
      stall_q  <= 1'b0;
      we_q     <= 1'b0;
      wreg_q   <= '0;
      wdata_q  <= '0;
    end else begin
      live_q   <= live_d;
      rd_q     <= rd_d;
      wr_q     <= wr_d;
      cnt_q    <= cnt_d;
      starve_q <= starve_d;
      stall_q  <= stall_d;
      we_q     <= we_d;
      wreg_q   <= wreg_d;
      wdata_q  <= wdata_d;
    end
  end

  // Entry payload needs no reset: live bits gate every use.
  always_ff @(posedge clk) begin
    ent_reg_q  <= ent_reg_d;
    ent_data_q <= ent_data_d;
  end

endmodule

// File: tb/tb_cpu_writeback_arbiter.sv
// Testbench for cpu_writeback_arbiter: vector table plus
// hand sequences for reset, full buffer and starvation.
module tb_cpu_writeback_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        alu_valid = 1'b0;
  logic [3:0]  alu_reg = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [3:0]  ld_reg = '0;
  logic [31:0] ld_data = '0;
  logic        write_enable;
  logic [3:0]  write_reg;
  logic [31:0] write_data;
  logic [2:0]  fifo_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  cpu_writeback_arbiter dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg),
    .alu_data(alu_data), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_reg(ld_reg), .ld_data(ld_data),
    .write_enable(write_enable), .write_reg(write_reg),
    .write_data(write_data), .fifo_count(fifo_count)
  );

  typedef struct {
    logic av; logic [3:0] ar; logic [31:0] ad;
    logic lv; logic [3:0] lr; logic [31:0] ld;
    logic we; logic [3:0] wr; logic [31:0] wd;
    logic [2:0] cnt; logic rdy; logic st;
  } vec_t;

  vec_t tbl[19];
  vec_t expq[$];
  logic [35:0] ldq[$];

  function automatic vec_t mk(int av, int ar, int ad, int lv,
                              int lr, int ld, int we, int wr,
                              int wd, int cnt, int rdy, int st);
    vec_t v;
    v.av = 1'(av); v.ar = 4'(ar); v.ad = 32'(ad);
    v.lv = 1'(lv); v.lr = 4'(lr); v.ld = 32'(ld);
    v.we = 1'(we); v.wr = 4'(wr); v.wd = 32'(wd);
    v.cnt = 3'(cnt); v.rdy = 1'(rdy); v.st = 1'(st);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int av, input int ar, input int ad,
                       input int lv, input int lr, input int ld);
    alu_valid = 1'(av); alu_reg = 4'(ar); alu_data = 32'(ad);
    ld_valid = 1'(lv); ld_reg = 4'(lr); ld_data = 32'(ld);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t e;
    logic hs;
    logic [35:0] x;
    int acc;
    logic done;

    tbl[0]  = mk(0,0,0,     0,0,0,       0,0,0,       0,1,0);
    tbl[1]  = mk(0,0,0,     1,5,'hCAFE,  1,5,'hCAFE,  0,1,0);
    tbl[2]  = mk(0,0,0,     0,0,0,       0,5,'hCAFE,  0,1,0);
    tbl[3]  = mk(1,1,'h11,  1,2,'h22,    1,1,'h11,    1,1,0);
    tbl[4]  = mk(1,3,'h33,  1,4,'h44,    1,3,'h33,    2,1,0);
    tbl[5]  = mk(0,0,0,     0,0,0,       1,2,'h22,    1,1,0);
    tbl[6]  = mk(0,0,0,     0,0,0,       1,4,'h44,    0,1,0);
    tbl[7]  = mk(0,0,0,     0,0,0,       0,4,'h44,    0,1,0);
    tbl[8]  = mk(1,9,'h99,  1,7,1,       1,9,'h99,    1,1,0);
    tbl[9]  = mk(1,7,2,     0,0,0,       1,7,2,       1,1,0);
    tbl[10] = mk(0,0,0,     0,0,0,       0,7,2,       0,1,0);
    tbl[11] = mk(1,7,3,     1,7,4,       1,7,3,       1,1,0);
    tbl[12] = mk(0,0,0,     0,0,0,       0,7,3,       0,1,0);
    tbl[13] = mk(0,0,0,     1,0,'h55,    1,0,'h55,    0,1,0);
    tbl[14] = mk(1,0,'h66,  0,0,0,       1,0,'h66,    0,1,0);
    tbl[15] = mk(1,1,'hA1,  1,2,'hB2,    1,1,'hA1,    1,1,0);
    tbl[16] = mk(0,0,0,     1,3,'hC3,    1,2,'hB2,    1,1,0);
    tbl[17] = mk(0,0,0,     0,0,0,       1,3,'hC3,    0,1,0);
    tbl[18] = mk(0,0,0,     0,0,0,       0,3,'hC3,    0,1,0);

    // reset state
    tick; tick;
    chk("rst_we", 32'(write_enable), 0);
    chk("rst_reg", 32'(write_reg), 0);
    chk("rst_data", write_data, 0);
    chk("rst_cnt", 32'(fifo_count), 0);
    chk("rst_rdy", 32'(ld_ready), 1);
    chk("rst_stall", 32'(alu_stall), 0);
    reset = 1'b0;

    // table: bypass, priority/drain, kill, r0, push+pop
    for (int i = 0; i < 19; i++) begin
      drive(tbl[i].av, tbl[i].ar, tbl[i].ad,
            tbl[i].lv, tbl[i].lr, tbl[i].ld);
      expq.push_back(tbl[i]);
      tick;
      e = expq.pop_front();
      chk($sformatf("v%0d_we", i), 32'(write_enable), 32'(e.we));
      chk($sformatf("v%0d_reg", i), 32'(write_reg), 32'(e.wr));
      chk($sformatf("v%0d_data", i), write_data, e.wd);
      chk($sformatf("v%0d_cnt", i), 32'(fifo_count), 32'(e.cnt));
      chk($sformatf("v%0d_rdy", i), 32'(ld_ready), 32'(e.rdy));
      chk($sformatf("v%0d_stall", i), 32'(alu_stall), 32'(e.st));
    end

    // T1: reset mid-drain discards buffered loads
    for (int i = 0; i < 3; i++) begin
      drive(1, 8 + i, 'h80 + i, 1, 1 + i, 'hD1 + i);
      tick;
    end
    chk("t1_cnt3", 32'(fifo_count), 3);
    drive(0, 0, 0, 0, 0, 0);
    tick;
    chk("t1_drain_data", write_data, 'hD1);
    chk("t1_cnt2", 32'(fifo_count), 2);
    #2 reset = 1'b1;
    #1;
    chk("t1_async_cnt", 32'(fifo_count), 0);
    chk("t1_async_we", 32'(write_enable), 0);
    tick;
    chk("t1_cnt", 32'(fifo_count), 0);
    chk("t1_rdy", 32'(ld_ready), 1);
    chk("t1_we", 32'(write_enable), 0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("t1_idle%0d_we", i), 32'(write_enable), 0);
      chk($sformatf("t1_idle%0d_cnt", i), 32'(fifo_count), 0);
    end

    // T5: fill the buffer under ALU pressure
    for (int i = 0; i < 4; i++) begin
      drive(1, 8 + i, 'h900 + i, 1, 1 + i, 'h500 + i);
      chk($sformatf("t5_rdy%0d", i), 32'(ld_ready), 1);
      ldq.push_back({4'(1 + i), 32'('h500 + i)});
      tick;
      chk($sformatf("t5_alu%0d", i), write_data, 'h900 + i);
    end
    chk("t5_cnt4", 32'(fifo_count), 4);
    chk("t5_full", 32'(ld_ready), 0);
    chk("t5_stall", 32'(alu_stall), 1);
    drive(1, 12, 'h90C, 1, 5, 'h505);
    tick;
    chk("t5_no_push", 32'(fifo_count), 4);
    chk("t5_alu_wins", write_data, 'h90C);
    chk("t5_stall_once", 32'(alu_stall), 0);
    alu_valid = 1'b0;
    acc = 0;
    done = 1'b0;
    for (int c = 0; c < 16 && !done; c++) begin
      hs = ld_valid && ld_ready;
      tick;
      if (hs) begin
        ldq.push_back({ld_reg, ld_data});
        ld_valid = 1'b0;
        acc++;
      end
      if (write_enable) begin
        chk("t5_wr_pending", 32'(ldq.size() != 0), 1);
        if (ldq.size() != 0) begin
          x = ldq.pop_front();
          chk("t5_order", {28'b0, write_reg}, {28'b0, x[35:32]});
          chk("t5_data", write_data, x[31:0]);
        end
      end
      done = (ldq.size() == 0) && !ld_valid;
    end
    chk("t5_timeout", 32'(done), 1);
    chk("t5_once", acc, 1);
    tick;
    chk("t5_idle_we", 32'(write_enable), 0);
    chk("t5_cnt0", 32'(fifo_count), 0);

    // T6: starvation bubble
    drive(1, 8, 'hA0, 1, 1, 'h601);
    tick;
    chk("t6_cnt", 32'(fifo_count), 1);
    for (int i = 0; i < 3; i++) begin
      drive(1, 9 + i, 'hA1 + i, 0, 0, 0);
      tick;
      chk($sformatf("t6_stall%0d", i), 32'(alu_stall), i == 2);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick;
    chk("t6_head_we", 32'(write_enable), 1);
    chk("t6_head_reg", 32'(write_reg), 1);
    chk("t6_head_data", write_data, 'h601);
    chk("t6_stall_drop", 32'(alu_stall), 0);
    drive(1, 8, 'hB0, 1, 2, 'h602);
    tick;
    for (int i = 0; i < 3; i++) begin
      drive(1, 9 + i, 'hB1 + i, 0, 0, 0);
      tick;
      chk($sformatf("t6_re%0d", i), 32'(alu_stall), i == 2);
    end
    drive(0, 0, 0, 0, 0, 0);
    tick;
    chk("t6_head2_data", write_data, 'h602);
    chk("t6_cnt_end", 32'(fifo_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
